hazard_controller: RTL and testbench

//  Pipeline hazard sequencer for the 5-stage RV32I core; drives the forwarding muxes at EX operand inputs.

---
 rtl/hazard_controller.sv | 141 ++++++++++++++
 tb/tb_hazard_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Load-use stall / branch flush sequencer with registered EX operand forwarding selects; optional HAZ_PERF_EN stall counter.
// Latency: stall_id/flush_ex combinational, fwd_*_sel registered at the edge the ID instruction enters EX; 1-cycle load-use penalty.
// Backpressure: stall_id holds PC and IF/ID for exactly one cycle per load-use; flush_ex bubbles ID/EX.
module hazard_controller #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_br_taken,
   output logic              stall_id,
   output logic              flush_ex,
   output logic [1:0]        fwd_rs1_sel,
   output logic [1:0]        fwd_rs2_sel
`ifdef HAZ_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } slot_t;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   logic [0:0] state_q;
   logic [0:0] state_d;
   slot_t      ex_q;
   slot_t      mem_q;
   slot_t      wb_q;
   slot_t      id_slot;
   logic       load_use;
   logic       stall_raw;
   logic       flush_raw;
   logic       ex_bubble;

   function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r);
      return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
   endfunction

   // Selects describe where the producer sits one cycle later, when the consumer is in EX.
   function automatic logic [1:0] fwd_pick(input slot_t ex_s, input slot_t mem_s,
                                           input logic [REG_AW-1:0] r);
      if (slot_match(ex_s, r)) begin
         return SEL_MEM;
      end else if (slot_match(mem_s, r)) begin
         return SEL_WB;
      end
      return SEL_RF;
   endfunction

   assign id_slot  = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
   assign load_use = id_valid && ex_q.memread &&
                     (slot_match(ex_q, id_rs1) || slot_match(ex_q, id_rs2));

   always_comb begin
      stall_raw = 1'b0;
      flush_raw = 1'b0;
      state_d   = state_q;
      case (state_q)
         ST_RUN: begin
            if (ex_br_taken) begin
               flush_raw = 1'b1;
            end else if (load_use) begin
               stall_raw = 1'b1;
               flush_raw = 1'b1;
               state_d   = ST_STALL;
            end
         end
         ST_STALL: begin
            flush_raw = ex_br_taken;
            state_d   = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Flops are held in reset anyway; only the visible outputs need explicit gating.
   assign stall_id  = stall_raw && rst_n;
   assign flush_ex  = flush_raw && rst_n;
   assign ex_bubble = stall_raw || flush_raw || !id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_rs1_sel <= SEL_RF;
         fwd_rs2_sel <= SEL_RF;
      end else begin
         state_q <= state_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         if (ex_bubble) begin
            ex_q        <= '0;
            fwd_rs1_sel <= SEL_RF;
            fwd_rs2_sel <= SEL_RF;
         end else begin
            ex_q        <= id_slot;
            fwd_rs1_sel <= fwd_pick(ex_q, mem_q, id_rs1);
            fwd_rs2_sel <= fwd_pick(ex_q, mem_q, id_rs2);
         end
      end
   end

   // WB producers are covered by regfile write-through; the slot is kept for debug visibility.
   logic unused_ok;

`ifdef HAZ_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_raw && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign unused_ok = ^{wb_q, mem_q.memread};
`else
   assign unused_ok = ^{wb_q, mem_q.memread, (CNT_W > 0)};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized bench for hazard_controller against a queue-based pipeline reference model.
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic       id_regwrite;
   logic       id_memread;
   logic       ex_br_taken;
   logic       stall_id;
   logic       flush_ex;
   logic [1:0] fwd_rs1_sel;
   logic [1:0] fwd_rs2_sel;
`ifdef HAZ_PERF_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_controller #(.REG_AW(5), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .ex_br_taken (ex_br_taken),
      .stall_id    (stall_id),
      .flush_ex    (flush_ex),
      .fwd_rs1_sel (fwd_rs1_sel),
      .fwd_rs2_sel (fwd_rs2_sel)
`ifdef HAZ_PERF_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   int         tests_run    = 0;
   int         tests_failed = 0;

   // hist holds what entered EX on each past edge, newest at the back (back = EX, back-1 = MEM).
   instr_t     hist[$];
   logic       m_pend;
   logic [1:0] m_sel1;
   logic [1:0] m_sel2;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic prod(input instr_t e, input logic [4:0] r);
      return e.v && e.rw && (e.rd != 5'd0) && (e.rd == r);
   endfunction

   function automatic logic [1:0] pick(input logic [4:0] r);
      if (prod(hist[hist.size()-1], r)) return 2'b01;
      if (prod(hist[hist.size()-2], r)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_pend = 1'b0;
      m_sel1 = 2'b00;
      m_sel2 = 2'b00;
      m_cnt  = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".fwd1"}, 32'(fwd_rs1_sel), 32'(m_sel1));
      chk({tag, ".fwd2"}, 32'(fwd_rs2_sel), 32'(m_sel2));
`ifdef HAZ_PERF_EN
      chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
   endtask

   task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic br);
      instr_t ex;
      instr_t nw;
      logic   lu;
      logic   e_stall;
      logic   e_flush;
      logic   nxt_pend;
      logic   bubble;
      @(negedge clk);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      ex_br_taken = br;
      #1;
      ex       = hist[hist.size()-1];
      lu       = v && ex.mr && (prod(ex, rs1) || prod(ex, rs2));
      e_stall  = 1'b0;
      e_flush  = 1'b0;
      nxt_pend = 1'b0;
      if (m_pend) begin
         e_flush = br;
      end else if (br) begin
         e_flush = 1'b1;
      end else if (lu) begin
         e_stall  = 1'b1;
         e_flush  = 1'b1;
         nxt_pend = 1'b1;
      end
      chk({tag, ".stall"}, 32'(stall_id), 32'(e_stall));
      chk({tag, ".flush"}, 32'(flush_ex), 32'(e_flush));
      check_regs(tag);
      bubble = e_stall || e_flush || !v;
      m_sel1 = bubble ? 2'b00 : pick(rs1);
      m_sel2 = bubble ? 2'b00 : pick(rs2);
      nw     = '0;
      if (!bubble) begin
         nw.v  = 1'b1;
         nw.rd = rd;
         nw.rw = rw;
         nw.mr = mr;
      end
      hist.push_back(nw);
      if (hist.size() > 3) void'(hist.pop_front());
      if (e_stall && (m_cnt < 65535)) m_cnt++;
      m_pend = nxt_pend;
   endtask

   // Drives hostile inputs during reset so any ungated output shows up.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n       = 1'b0;
      id_valid    = 1'b1;
      id_rs1      = 5'd1;
      id_rs2      = 5'd2;
      id_rd       = 5'd1;
      id_regwrite = 1'b1;
      id_memread  = 1'b1;
      ex_br_taken = 1'b1;
      #1;
      model_reset();
      chk({tag, ".stall"}, 32'(stall_id), 32'd0);
      chk({tag, ".flush"}, 32'(flush_ex), 32'd0);
      check_regs(tag);
      id_valid    = 1'b0;
      ex_br_taken = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   logic       r_v, r_rw, r_mr, r_br;
   logic [4:0] r_rs1, r_rs2, r_rd;

   initial begin
      rst_n       = 1'b1;
      id_valid    = 1'b0;
      id_rs1      = '0;
      id_rs2      = '0;
      id_rd       = '0;
      id_regwrite = 1'b0;
      id_memread  = 1'b0;
      ex_br_taken = 1'b0;
      model_reset();
      do_reset("rst0");

      // ALU chain: add x1 then sub x4 = x1 - x2
      step("alu_a", 1, 5'd0, 5'd0, 5'd1, 1, 0, 0);
      step("alu_b", 1, 5'd1, 5'd2, 5'd4, 1, 0, 0);
      step("alu_c", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // distance 2 on rs2
      step("d2_a", 1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
      step("d2_b", 1, 5'd7, 5'd8, 5'd9, 1, 0, 0);
      step("d2_c", 1, 5'd6, 5'd3, 5'd10, 1, 0, 0);
      step("d2_d", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // x0 writer is never forwarded
      step("x0_a", 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      step("x0_b", 1, 5'd0, 5'd11, 5'd12, 1, 0, 0);
      step("x0_c", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // load-use: lw x5 then use x5, ID held through the stall
      step("lu_a", 1, 5'd0, 5'd0, 5'd5, 1, 1, 0);
      step("lu_b", 1, 5'd5, 5'd0, 5'd13, 1, 0, 0);
      step("lu_c", 1, 5'd5, 5'd0, 5'd13, 1, 0, 0);
      step("lu_d", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      step("lu_e", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // branch during load-use wins
      step("br_a", 1, 5'd0, 5'd0, 5'd6, 1, 1, 0);
      step("br_b", 1, 5'd0, 5'd6, 5'd14, 1, 0, 1);
      step("br_c", 1, 5'd6, 5'd0, 5'd15, 1, 0, 0);
      step("br_d", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      // reset in the middle of a stall
      step("rs_a", 1, 5'd0, 5'd0, 5'd5, 1, 1, 0);
      step("rs_b", 1, 5'd5, 5'd5, 5'd2, 1, 0, 0);
      do_reset("rst_mid");
      step("rs_c", 1, 5'd5, 5'd5, 5'd2, 1, 0, 0);
      step("rs_d", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

      r_v = 0; r_rs1 = 0; r_rs2 = 0; r_rd = 0; r_rw = 0; r_mr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset("rst_rnd");
         end
         // ID holds its instruction while stalled
         if (!m_pend) begin
            r_v   = ($urandom_range(0, 99) < 85);
            r_rs1 = 5'($urandom_range(0, 3));
            r_rs2 = 5'($urandom_range(0, 3));
            r_rd  = 5'($urandom_range(0, 3));
            r_rw  = ($urandom_range(0, 99) < 80);
            r_mr  = r_rw && ($urandom_range(0, 99) < 35);
         end
         r_br = ($urandom_range(0, 99) < 8);
         step("rnd", r_v, r_rs1, r_rs2, r_rd, r_rw, r_mr, r_br);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
